// File: rtl/uart_bus_pkg.sv
// Shared definitions for the memory-mapped UART slave: register addresses,
// CON bit positions and the transmitter/receiver state encodings.
package uart_bus_pkg;

    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    localparam int CON_TX_IE      = 0;
    localparam int CON_RX_IE      = 1;
    localparam int CON_TX_DONE    = 2;
    localparam int CON_RX_READY   = 3;
    localparam int CON_TX_BUSY    = 4;
    localparam int CON_RX_OVERRUN = 5;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receiver: two-flop synchronizer, falling-edge start detection and a
// mid-bit sampling 8N1 state machine. Emits a one-cycle o_valid pulse with the
// received byte on o_data; false starts and framing errors produce no pulse.
module uart_rx_fsm
    import uart_bus_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic       o_valid,
    output logic [7:0] o_data
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_rxPrev;
    rx_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bitIdx;
    logic [7:0]    r_shift;
    logic          r_valid;

    rx_state_t     w_stateNext;
    logic [CW-1:0] w_cntNext;
    logic [2:0]    w_bitIdxNext;
    logic [7:0]    w_shiftNext;
    logic          w_validNext;

    // Synchronize the asynchronous line and remember its previous value for edge detection
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_sync1  <= i_rx;
            r_sync2  <= r_sync1;
            r_rxPrev <= r_sync2;
        end
    end

    // Receiver state register, baud counter and shift register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= RX_IDLE;
            r_cnt    <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_cnt    <= w_cntNext;
            r_bitIdx <= w_bitIdxNext;
            r_shift  <= w_shiftNext;
            r_valid  <= w_validNext;
        end
    end

    // Next-state logic: half a bit into the start bit, then one full bit per data/stop sample
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_bitIdxNext = r_bitIdx;
        w_shiftNext  = r_shift;
        w_validNext  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cntNext    = '0;
                w_bitIdxNext = '0;
                if (r_rxPrev && !r_sync2) begin
                    w_stateNext = RX_START;
                end
            end
            RX_START: begin
                if (r_cnt == HALF_CNT) begin
                    w_cntNext   = '0;
                    w_stateNext = r_sync2 ? RX_IDLE : RX_DATA;
                end else begin
                    w_cntNext = r_cnt + CW'(1);
                end
            end
            RX_DATA: begin
                if (r_cnt == LAST_CNT) begin
                    w_cntNext   = '0;
                    w_shiftNext = {r_sync2, r_shift[7:1]};
                    if (r_bitIdx == 3'd7) begin
                        w_stateNext = RX_STOP;
                    end else begin
                        w_bitIdxNext = r_bitIdx + 3'd1;
                    end
                end else begin
                    w_cntNext = r_cnt + CW'(1);
                end
            end
            RX_STOP: begin
                if (r_cnt == LAST_CNT) begin
                    w_cntNext   = '0;
                    w_stateNext = RX_IDLE;
                    w_validNext = r_sync2;
                end else begin
                    w_cntNext = r_cnt + CW'(1);
                end
            end
            default: begin
                w_stateNext = RX_IDLE;
            end
        endcase
    end

    assign o_valid = r_valid;
    assign o_data  = r_shift;

endmodule

// File: rtl/uart_bus_slave.sv
// Memory-mapped UART for a single-cycle CPU: TXD/RXD/CON registers with
// zero-latency reads, an 8N1 transmitter and the uart_rx_fsm receiver, plus a
// registered level interrupt.
module uart_bus_slave
    import uart_bus_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    tx_state_t     r_txState;
    logic [CW-1:0] r_txCnt;
    logic [2:0]    r_txIdx;
    logic [7:0]    r_txBuf;
    logic          r_txLine;
    logic          r_txIe;
    logic          r_rxIe;
    logic          r_txDone;
    logic          r_rxReady;
    logic          r_rxOverrun;
    logic [7:0]    r_rxd;
    logic          r_irq;

    tx_state_t     w_txStateNext;
    logic [CW-1:0] w_txCntNext;
    logic [2:0]    w_txIdxNext;
    logic [2:0]    w_txIdxPlus;
    logic [7:0]    w_txBufNext;
    logic          w_txLineNext;
    logic          w_txDoneSet;
    logic          w_txBusy;
    logic          w_wrTxd;
    logic          w_wrCon;
    logic          w_rdRxd;
    logic          w_rdCon;
    logic          w_rxValid;
    logic [7:0]    w_rxData;
    logic [31:0]   w_conValue;
    logic          w_unusedWdata;

    assign w_wrTxd       = wr && (addr == ADDR_TXD);
    assign w_wrCon       = wr && (addr == ADDR_CON);
    assign w_rdRxd       = rd && (addr == ADDR_RXD);
    assign w_rdCon       = rd && (addr == ADDR_CON);
    assign w_txBusy      = (r_txState != TX_IDLE);
    assign w_txIdxPlus   = r_txIdx + 3'd1;
    assign w_unusedWdata = ^wdata[31:8];

    assign w_conValue = {26'd0, r_rxOverrun, w_txBusy, r_rxReady, r_txDone, r_rxIe, r_txIe};

    uart_rx_fsm #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_clk   (clk),
        .i_reset (reset),
        .i_rx    (uart_rx),
        .o_valid (w_rxValid),
        .o_data  (w_rxData)
    );

    // Transmitter state register, baud counter, bit index, byte buffer and line driver
    always_ff @(posedge clk) begin
        if (reset) begin
            r_txState <= TX_IDLE;
            r_txCnt   <= '0;
            r_txIdx   <= '0;
            r_txBuf   <= '0;
            r_txLine  <= 1'b1;
        end else begin
            r_txState <= w_txStateNext;
            r_txCnt   <= w_txCntNext;
            r_txIdx   <= w_txIdxNext;
            r_txBuf   <= w_txBufNext;
            r_txLine  <= w_txLineNext;
        end
    end

    // Transmitter next-state logic; the line value for the coming bit is registered at each bit boundary
    always_comb begin
        w_txStateNext = r_txState;
        w_txCntNext   = r_txCnt;
        w_txIdxNext   = r_txIdx;
        w_txBufNext   = r_txBuf;
        w_txLineNext  = r_txLine;
        w_txDoneSet   = 1'b0;
        case (r_txState)
            TX_IDLE: begin
                w_txCntNext  = '0;
                w_txIdxNext  = '0;
                w_txLineNext = 1'b1;
                if (w_wrTxd) begin
                    w_txBufNext   = wdata[7:0];
                    w_txLineNext  = 1'b0;
                    w_txStateNext = TX_START;
                end
            end
            TX_START: begin
                if (r_txCnt == LAST_CNT) begin
                    w_txCntNext   = '0;
                    w_txLineNext  = r_txBuf[0];
                    w_txStateNext = TX_DATA;
                end else begin
                    w_txCntNext = r_txCnt + CW'(1);
                end
            end
            TX_DATA: begin
                if (r_txCnt == LAST_CNT) begin
                    w_txCntNext = '0;
                    if (r_txIdx == 3'd7) begin
                        w_txLineNext  = 1'b1;
                        w_txStateNext = TX_STOP;
                    end else begin
                        w_txIdxNext  = w_txIdxPlus;
                        w_txLineNext = r_txBuf[w_txIdxPlus];
                    end
                end else begin
                    w_txCntNext = r_txCnt + CW'(1);
                end
            end
            TX_STOP: begin
                if (r_txCnt == LAST_CNT) begin
                    w_txCntNext   = '0;
                    w_txStateNext = TX_IDLE;
                    w_txDoneSet   = 1'b1;
                end else begin
                    w_txCntNext = r_txCnt + CW'(1);
                end
            end
            default: begin
                w_txStateNext = TX_IDLE;
            end
        endcase
    end

    // Control bits, status flags and received byte; a flag set always beats a same-edge clear-on-read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_txIe      <= 1'b0;
            r_rxIe      <= 1'b0;
            r_txDone    <= 1'b0;
            r_rxReady   <= 1'b0;
            r_rxOverrun <= 1'b0;
            r_rxd       <= '0;
        end else begin
            if (w_wrCon) begin
                r_txIe <= wdata[CON_TX_IE];
                r_rxIe <= wdata[CON_RX_IE];
            end
            if (w_txDoneSet) begin
                r_txDone <= 1'b1;
            end else if (w_rdCon) begin
                r_txDone <= 1'b0;
            end
            if (w_rxValid) begin
                r_rxReady <= 1'b1;
                r_rxd     <= w_rxData;
            end else if (w_rdRxd) begin
                r_rxReady <= 1'b0;
            end
            if (w_rxValid && r_rxReady) begin
                r_rxOverrun <= 1'b1;
            end else if (w_rdCon) begin
                r_rxOverrun <= 1'b0;
            end
        end
    end

    // Registered level interrupt, trailing the flags by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_txIe && r_txDone) || (r_rxIe && r_rxReady);
        end
    end

    // Zero-latency read mux; anything but an exact mapped read returns zero
    always_comb begin
        rdata = 32'd0;
        if (rd) begin
            if (addr == ADDR_RXD) begin
                rdata = {24'd0, r_rxd};
            end else if (addr == ADDR_CON) begin
                rdata = w_conValue;
            end
        end
    end

    assign uart_tx = r_txLine;
    assign irq     = r_irq;

endmodule
